demux_1x2_16bit_buf: RTL

- Buffered 1-to-2 demultiplexer: the routing counterpart of the 16-bit 2:1 select mux in the datapath.
- Accepts one WIDTH-bit word per handshake and steers it to one of two destination channels (e.g. register-file write path vs. HI/LO / memory-store path).
- Each destination has its own small FIFO, so a stalled destination does not block traffic to the other one.
- Each channel keeps a count of words routed to it, for debug.

---
 rtl/demux_1x2_16bit_buf_if.sv | 29 ++
 rtl/demux_1x2_16bit_buf.sv | 70 +++++++
 2 files changed

// File: rtl/demux_1x2_16bit_buf_if.sv
// Handshake bundle for the buffered 1:2 demux: one producer port, two consumer
// ports and the per-channel routed-word counters.
interface demux_1x2_16bit_buf_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1x2_16bit_buf.sv
// Buffered 1:2 demux: each accepted word lands in the FWFT FIFO picked by
// in_sel, so a stalled destination never blocks the other channel.
module demux_1x2_16bit_buf #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_1x2_16bit_buf_if.slave    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem   [2][DEPTH];
  logic [PW-1:0]    wptr  [2];
  logic [PW-1:0]    rptr  [2];
  logic [CNT_W-1:0] cnt   [2];
  logic             full  [2];
  logic             empty [2];
  logic             push  [2];
  logic             pop   [2];
  logic             rdy   [2];

  // FIFO status from registered pointers only; outN_ready never reaches in_ready.
  always_comb begin
    rdy[0] = bus.out0_ready;
    rdy[1] = bus.out1_ready;
    for (int c = 0; c < 2; c++) begin
      empty[c] = (wptr[c] == rptr[c]);
      full[c]  = (wptr[c][AW] != rptr[c][AW]) &&
                 (wptr[c][AW-1:0] == rptr[c][AW-1:0]);
      push[c]  = bus.in_valid && !full[c] && (bus.in_sel == 1'(c));
      pop[c]   = !empty[c] && rdy[c];
    end
  end

  assign bus.in_ready   = !full[bus.in_sel];
  assign bus.out0_valid = !empty[0];
  assign bus.out1_valid = !empty[1];
  assign bus.out0_data  = empty[0] ? '0 : mem[0][rptr[0][AW-1:0]];
  assign bus.out1_data  = empty[1] ? '0 : mem[1][rptr[1][AW-1:0]];
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];

  // Storage, pointers and counters; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
        for (int e = 0; e < int'(DEPTH); e++) begin
          mem[c][e] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wptr[c][AW-1:0]] <= bus.in_data;
          wptr[c]                 <= wptr[c] + PW'(1);
          cnt[c]                  <= cnt[c] + CNT_W'(1);
        end
        if (pop[c]) begin
          rptr[c] <= rptr[c] + PW'(1);
        end
      end
    end
  end
endmodule
